// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake
// and presents a 2-entry buffer of {pc,inst} pairs to the IF/ID register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  localparam logic [1:0] FULL_CNT = 2'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic        v0_q, v0_d, v1_q, v1_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] in0_q, in0_d, in1_q, in1_d;
  logic        ack_s, pop_s, push_s;
  logic        sv0_s, sv1_s;
  logic [31:0] spc0_s, spc1_s, sin0_s, sin1_s;
  logic [1:0]  count_d;

  // Next-state: buffer pop/push, fetch FSM, and branch flush/redirect.
  always_comb begin
    ack_s      = imem_ack_i & req_q;
    pop_s      = v0_q & ~stall_i;
    push_s     = ack_s & (state_q == S_BUSY);
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    sv0_s      = 1'b0;
    sv1_s      = 1'b0;
    spc0_s     = 32'd0;
    spc1_s     = 32'd0;
    sin0_s     = 32'd0;
    sin1_s     = 32'd0;
    v0_d       = 1'b0;
    v1_d       = 1'b0;
    pc0_d      = 32'd0;
    pc1_d      = 32'd0;
    in0_d      = 32'd0;
    in1_d      = 32'd0;
    count_d    = 2'd0;
    if (branch_flag_i) begin
      // Buffer stays cleared; an in-flight fetch must still complete before
      // the target can be requested.
      fetch_pc_d = {branch_target_i[31:2], 2'b00};
      state_d    = ((state_q != S_IDLE) && !ack_s) ? S_DROP : S_BUSY;
    end else begin
      // Entries are kept head-packed: pop shifts entry 1 down, push fills the
      // lowest free slot. Empty slots always hold zeros.
      sv0_s   = pop_s ? v1_q  : v0_q;
      spc0_s  = pop_s ? pc1_q : pc0_q;
      sin0_s  = pop_s ? in1_q : in0_q;
      sv1_s   = pop_s ? 1'b0  : v1_q;
      spc1_s  = pop_s ? 32'd0 : pc1_q;
      sin1_s  = pop_s ? 32'd0 : in1_q;
      v0_d    = sv0_s | push_s;
      pc0_d   = (push_s && !sv0_s) ? fetch_pc_q   : spc0_s;
      in0_d   = (push_s && !sv0_s) ? imem_rdata_i : sin0_s;
      v1_d    = sv1_s | (push_s & sv0_s);
      pc1_d   = (push_s && sv0_s) ? fetch_pc_q   : spc1_s;
      in1_d   = (push_s && sv0_s) ? imem_rdata_i : sin1_s;
      count_d = {1'b0, v0_d} + {1'b0, v1_d};
      case (state_q)
        S_IDLE: state_d = (count_d < FULL_CNT) ? S_BUSY : S_IDLE;
        S_BUSY: begin
          if (ack_s) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = (count_d < FULL_CNT) ? S_BUSY : S_IDLE;
          end else begin
            state_d    = S_BUSY;
          end
        end
        S_DROP:  state_d = ack_s ? S_BUSY : S_DROP;
        default: state_d = S_IDLE;
      endcase
    end
    req_d  = (state_d != S_IDLE);
    addr_d = (state_d == S_DROP) ? addr_q : fetch_pc_d;
  end

  // State, request and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= 32'd0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      pc0_q      <= 32'd0;
      pc1_q      <= 32'd0;
      in0_q      <= 32'd0;
      in1_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
      in0_q      <= in0_d;
      in1_q      <= in1_d;
    end
  end

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign if_valid_o  = v0_q;
  assign if_pc       = pc0_q;
  assign if_inst     = in0_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, hand-written corner sequences
// and a randomized run checked against a program-order reference model.
module tb_if_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, branch;
  logic [31:0] target;
  logic        req, ack, valid;
  logic [31:0] addr, rdata, pc, inst;
  logic        req2, ack2, valid2;
  logic [31:0] addr2, rdata2, pc2, inst2;

  int tests = 0;
  int fails = 0;
  int delay = 0;
  int wcnt  = 0;
  bit rand_ack = 1'b0;

  if_fetch_unit #(.RESET_PC(32'h0000_0100), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(branch),
    .branch_target_i(target), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_rdata_i(rdata), .if_valid_o(valid),
    .if_pc(pc), .if_inst(inst)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut_w (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(branch),
    .branch_target_i(target), .imem_req_o(req2), .imem_addr_o(addr2),
    .imem_ack_i(ack2), .imem_rdata_i(rdata2), .if_valid_o(valid2),
    .if_pc(pc2), .if_inst(inst2)
  );

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs (memory responds from the current request), then
  // advance to the next falling edge where outputs are sampled.
  task automatic cyc(input logic s, input logic b, input logic [31:0] t);
    stall  = s;
    branch = b;
    target = t;
    if (rst) begin
      ack  = 1'b0;
      wcnt = 0;
    end else if (rand_ack) begin
      ack = ($urandom_range(0, 1) == 1);
    end else if (req) begin
      if (wcnt >= delay) begin
        ack  = 1'b1;
        wcnt = 0;
      end else begin
        ack  = 1'b0;
        wcnt++;
      end
    end else begin
      ack  = 1'b0;
      wcnt = 0;
    end
    rdata  = memfn(addr);
    ack2   = req2 && !rst;
    rdata2 = memfn(addr2);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!valid && n < budget) begin
      cyc(1'b0, 1'b0, 32'd0);
      n++;
    end
    chk({name, " timeout"}, 32'(valid), 32'd1);
  endtask

  typedef struct {
    logic        stall;
    logic        vld;
    logic [31:0] pc;
    logic        rq;
    logic [31:0] ad;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic [31:0] exp_pc, exp_inst, prev_addr, t;
    logic        prev_req, prev_ack, s, b;
    int          consumed;

    rst = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'd0;
    ack = 1'b0; rdata = 32'd0; ack2 = 1'b0; rdata2 = 32'd0;

    // Zero-wait memory, then a 5-cycle stall starting while 0x104 is presented.
    vt[0]  = '{1'b0, 1'b0, 32'h000, 1'b0, 32'h000};
    vt[1]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h100};
    vt[2]  = '{1'b0, 1'b1, 32'h100, 1'b1, 32'h104};
    vt[3]  = '{1'b1, 1'b1, 32'h104, 1'b1, 32'h108};
    vt[4]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h000};
    vt[5]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h000};
    vt[6]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h000};
    vt[7]  = '{1'b1, 1'b1, 32'h104, 1'b0, 32'h000};
    vt[8]  = '{1'b0, 1'b1, 32'h104, 1'b0, 32'h000};
    vt[9]  = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h10C};
    vt[10] = '{1'b0, 1'b1, 32'h10C, 1'b1, 32'h110};
    vt[11] = '{1'b0, 1'b1, 32'h110, 1'b1, 32'h114};

    do_reset();
    delay = 0;
    chk("rst addr", addr, 32'd0);
    chk("rst inst", inst, 32'd0);
    chk("rst wrap valid", 32'(valid2), 32'd0);
    for (int i = 0; i < 12; i++) begin
      exp_inst = vt[i].vld ? memfn(vt[i].pc) : 32'd0;
      chk($sformatf("tbl valid[%0d]", i), 32'(valid), 32'(vt[i].vld));
      chk($sformatf("tbl pc[%0d]", i), pc, vt[i].pc);
      chk($sformatf("tbl inst[%0d]", i), inst, exp_inst);
      chk($sformatf("tbl req[%0d]", i), 32'(req), 32'(vt[i].rq));
      if (vt[i].rq) chk($sformatf("tbl addr[%0d]", i), addr, vt[i].ad);
      // The wrap instance sees the same timing, offset so 0x100 maps to 0xFFFF_FFF8.
      chk($sformatf("wrap valid[%0d]", i), 32'(valid2), 32'(vt[i].vld));
      if (vt[i].vld) chk($sformatf("wrap pc[%0d]", i), pc2, vt[i].pc + 32'hFFFF_FEF8);
      if (vt[i].rq) chk($sformatf("wrap addr[%0d]", i), addr2, vt[i].ad + 32'hFFFF_FEF8);
      cyc(vt[i].stall, 1'b0, 32'd0);
    end

    // Delayed ack holds the address; then branch to 0x2003 while a fetch is pending.
    do_reset();
    delay = 3;
    cyc(1'b0, 1'b0, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wait req[%0d]", k), 32'(req), 32'd1);
      chk($sformatf("wait addr[%0d]", k), addr, 32'h100);
      chk($sformatf("wait valid[%0d]", k), 32'(valid), 32'd0);
      cyc(1'b0, 1'b0, 32'd0);
    end
    chk("slow pc0", pc, 32'h100);
    chk("slow inst0", inst, memfn(32'h100));
    chk("slow addr1", addr, 32'h104);
    cyc(1'b1, 1'b0, 32'd0);
    chk("stalled pc", pc, 32'h100);
    cyc(1'b1, 1'b1, 32'h2003);
    chk("flush valid", 32'(valid), 32'd0);
    chk("flush pc", pc, 32'd0);
    chk("drop addr a", addr, 32'h104);
    cyc(1'b0, 1'b0, 32'd0);
    chk("drop addr b", addr, 32'h104);
    cyc(1'b0, 1'b0, 32'd0);
    chk("redirect addr", addr, 32'h2000);
    chk("redirect valid", 32'(valid), 32'd0);
    wait_valid("br first", 12);
    chk("br pc", pc, 32'h2000);
    chk("br inst", inst, memfn(32'h2000));
    cyc(1'b0, 1'b0, 32'd0);
    chk("pulse low", 32'(valid), 32'd0);
    wait_valid("br second", 12);
    chk("br pc2", pc, 32'h2004);

    // Branch with a same-cycle ack under stall, then branch while buffer is full.
    do_reset();
    delay = 0;
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    chk("ba pc", pc, 32'h100);
    chk("ba addr", addr, 32'h104);
    cyc(1'b1, 1'b1, 32'h3000);
    chk("ba flushed", 32'(valid), 32'd0);
    chk("ba req", 32'(req), 32'd1);
    chk("ba addr tgt", addr, 32'h3000);
    cyc(1'b0, 1'b0, 32'd0);
    chk("ba pc tgt", pc, 32'h3000);
    cyc(1'b1, 1'b0, 32'd0);
    chk("full req", 32'(req), 32'd0);
    chk("full pc", pc, 32'h3000);
    cyc(1'b1, 1'b1, 32'h4000);
    chk("full flushed", 32'(valid), 32'd0);
    chk("full req tgt", 32'(req), 32'd1);
    chk("full addr tgt", addr, 32'h4000);

    // Reset asserted while a fetch is outstanding.
    do_reset();
    delay = 3;
    cyc(1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 32'd0);
    chk("mid req", 32'(req), 32'd1);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 32'd0);
    chk("mid rst req", 32'(req), 32'd0);
    chk("mid rst addr", addr, 32'd0);
    chk("mid rst valid", 32'(valid), 32'd0);
    chk("mid rst pc", pc, 32'd0);
    rst = 1'b0;
    cyc(1'b0, 1'b0, 32'd0);
    chk("refetch addr", addr, 32'h100);
    wait_valid("refetch", 12);
    chk("refetch pc", pc, 32'h100);

    // Randomized run: consumed instructions must follow program order.
    do_reset();
    rand_ack  = 1'b1;
    exp_pc    = 32'h100;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 32'd0;
    consumed  = 0;
    for (int n = 0; n < 2000; n++) begin
      if (valid) begin
        chk("rnd inst", inst, memfn(pc));
      end else begin
        chk("rnd idle pc", pc, 32'd0);
        chk("rnd idle inst", inst, 32'd0);
      end
      if (prev_req && !prev_ack) begin
        chk("rnd req held", 32'(req), 32'd1);
        chk("rnd addr held", addr, prev_addr);
      end
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 15) == 0);
      t = $urandom;
      if (b) begin
        exp_pc = {t[31:2], 2'b00};
      end else if (valid && !s) begin
        chk("rnd order", pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      prev_req  = req;
      prev_addr = addr;
      cyc(s, b, t);
      prev_ack = ack;
    end
    chk("rnd progress", 32'(consumed >= 200), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
